// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU/memory types. Holds the word type, the RAM
//                handshake state reported by the RAM model, and the state
//                encoding of the memory controller FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Controller states, kept as sized constants of a named type so older
    // tools that dislike enum arithmetic can still consume them.
    typedef logic [1:0] memstate_t;
    localparam memstate_t IDLE = 2'd0;
    localparam memstate_t DACC = 2'd1;
    localparam memstate_t IACC = 2'd2;

    // Width of the access timeout counter.
    localparam int c_CNT_W = 10;

endpackage
`default_nettype wire

// File: rtl/memory_control.sv
`default_nettype none
// ============================================================================
//  Module      : memory_control
//  Description : Memory-side responder for the cache interface. Arbitrates
//                instruction and data requests onto one single-ported RAM,
//                data first, and returns wait/load responses. A per-access
//                timeout plus the RAM ERROR state abort hung accesses and set
//                a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter word_t       ERRWORD = 32'hBAD1BAD1
)(
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    memstate_t          r_state;
    memstate_t          w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_memerr;
    logic               w_set_err;
    logic               w_dreq;
    logic               w_done;
    logic               w_abort;

    assign w_dreq  = dREN | dWEN;
    // Completion wins over abort when the RAM answers in the timeout cycle.
    assign w_done  = (ramstate == ACCESS);
    assign w_abort = !w_done && ((ramstate == ERROR) || (r_cnt == c_TIMEOUT));

    // Next-state decode and all combinational outputs (strobes, waits, loads).
    always_comb begin
        w_state_next = r_state;
        w_set_err    = 1'b0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_state_next = DACC;
                end else if (iREN) begin
                    w_state_next = IACC;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (w_done) begin
                    dwait        = 1'b0;
                    dload        = dWEN ? '0 : ramload;
                    w_state_next = IDLE;
                end else if (w_abort) begin
                    dwait        = 1'b0;
                    dload        = ERRWORD;
                    w_set_err    = 1'b1;
                    w_state_next = IDLE;
                end else if (!w_dreq) begin
                    // Requester gave up: leave without a response.
                    w_state_next = IDLE;
                end
            end
            IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (w_done) begin
                    iwait        = 1'b0;
                    iload        = ramload;
                    w_state_next = IDLE;
                end else if (w_abort) begin
                    iwait        = 1'b0;
                    iload        = ERRWORD;
                    w_set_err    = 1'b1;
                    w_state_next = IDLE;
                end else if (!iREN) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Access timer: held at zero in IDLE so every grant starts from zero;
    // the abort fires at TIMEOUT, so the hold there only guards against wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (r_cnt != c_TIMEOUT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_memerr <= 1'b0;
        end else if (w_set_err) begin
            r_memerr <= 1'b1;
        end
    end

    assign memerr = r_memerr;

endmodule
`default_nettype wire

// File: tb/tb_memory_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_control
//  Description : Self-checking bench for memory_control. A RAM model answers
//                strobes; expected responses and RAM transactions are queued
//                when stimulus is issued and popped by independent monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_control;
    import cpu_types_pkg::*;

    localparam int unsigned c_TO   = 8;
    localparam word_t       c_ERRW = 32'hBAD1BAD1;
    localparam int          c_NORM = 0;
    localparam int          c_BUSY = 1;
    localparam int          c_ERRM = 2;
    // transaction kinds
    localparam int K_I   = 0;   // instruction read
    localparam int K_DR  = 1;   // data read
    localparam int K_DW  = 2;   // data write with dREN also high
    localparam int K_BTH = 3;   // data read and instruction read together
    localparam int K_DWO = 4;   // data write, dWEN only

    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t ramstate = FREE;
    logic      iwait, dwait, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    memory_control #(.TIMEOUT(c_TO), .ERRWORD(c_ERRW)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .iwait(iwait),
        .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { bit is_d; word_t load; bit err; int cyc; } resp_t;
    typedef struct { bit we; bit re; word_t addr; word_t store; } ramtx_t;
    resp_t  sb[$];
    ramtx_t rq[$];

    int    n_vec = 0, n_err = 0;
    bit    chk_en = 1'b0;
    bit    exp_memerr = 1'b0;
    int    ram_mode = 0, ram_lat = 0;
    word_t ref_mem [word_t];
    word_t ram_mem [word_t];

    function automatic word_t init_word(input word_t a);
        return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction
    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction
    function automatic word_t ram_rd(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction
    function automatic int eff_lat(input int mode, input int lat);
        return (mode == c_NORM) ? lat : (mode == c_BUSY) ? int'(c_TO) : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h expected no event (cycle %0d)", name, act, cyc);
    endtask

    // RAM model: counts strobe cycles of each burst and answers after ram_lat.
    initial begin : ram_model
        int     rcnt;
        ramtx_t t;
        rcnt = 0;
        forever begin
            @(negedge CLK); #1;
            if (!(ramREN || ramWEN)) begin
                ramstate = FREE;
                ramload  = '0;
                rcnt     = 0;
            end else begin
                if (rcnt == 0) begin
                    if (rq.size() == 0) begin
                        fail_evt("ram_unexpected_access", ramaddr);
                    end else begin
                        t = rq.pop_front();
                        chk("ram_addr",  ramaddr,  t.addr);
                        chk("ram_wen",   32'(ramWEN), 32'(t.we));
                        chk("ram_ren",   32'(ramREN), 32'(t.re));
                        chk("ram_store", ramstore, t.store);
                    end
                end
                ramload = 32'hFFFF_0000 ^ word_t'(rcnt);
                if (ram_mode == c_ERRM) begin
                    ramstate = ERROR;
                end else if (ram_mode == c_NORM && rcnt == ram_lat) begin
                    ramstate = ACCESS;
                    if (ramWEN) begin
                        ram_mem[ramaddr] = ramstore;
                        ramload = '0;
                    end else begin
                        ramload = ram_rd(ramaddr);
                    end
                end else begin
                    ramstate = BUSY;
                end
                rcnt++;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a wait drops.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge CLK); #3;
            if (chk_en) begin
                chk("memerr", 32'(memerr), 32'(exp_memerr));
                if (!ramREN && !ramWEN) begin
                    chk("ramaddr_idle",  ramaddr,  32'd0);
                    chk("ramstore_idle", ramstore, 32'd0);
                end
                if (iwait) chk("iload_gated", iload, 32'd0);
                if (dwait) chk("dload_gated", dload, 32'd0);
                if (!iwait || !dwait) begin
                    if (sb.size() == 0) begin
                        fail_evt("unexpected_wait_pulse", {30'd0, iwait, dwait});
                    end else begin
                        e = sb.pop_front();
                        chk("resp_port",  {30'd0, iwait, dwait}, e.is_d ? 32'd2 : 32'd1);
                        chk("resp_cycle", cyc, e.cyc);
                        chk("resp_load",  e.is_d ? dload : iload, e.load);
                        if (e.err) exp_memerr = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_low(input bit is_d);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge CLK); #4;
            seen = is_d ? !dwait : !iwait;
            n++;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_wait_timeout: got no response expected one within %0d cycles",
                     is_d ? "d" : "i", n);
        end
    endtask

    task automatic txn(input int kind, input word_t ia, input word_t da,
                       input word_t dd, input int mode, input int lat);
        int    c0, rl;
        bit    has_d, has_i, wr;
        resp_t e;
        @(negedge CLK);
        ram_mode = mode;
        ram_lat  = lat;
        c0    = cyc;
        rl    = eff_lat(mode, lat);
        has_d = (kind != K_I);
        has_i = (kind == K_I) || (kind == K_BTH);
        wr    = (kind == K_DW) || (kind == K_DWO);
        if (has_d) begin
            rq.push_back('{we: wr, re: !wr, addr: da, store: wr ? dd : 32'd0});
            e.is_d = 1'b1;
            e.cyc  = c0 + 1 + rl;
            e.err  = (mode != c_NORM);
            e.load = (mode != c_NORM) ? c_ERRW : (wr ? 32'd0 : ref_rd(da));
            sb.push_back(e);
            if (wr && mode == c_NORM) ref_mem[da] = dd;
        end
        if (has_i) begin
            rq.push_back('{we: 1'b0, re: 1'b1, addr: ia, store: 32'd0});
            e.is_d = 1'b0;
            e.cyc  = (has_d ? c0 + 2 + rl : c0) + 1 + rl;
            e.err  = (mode != c_NORM);
            e.load = (mode != c_NORM) ? c_ERRW : ref_rd(ia);
            sb.push_back(e);
        end
        iREN   = has_i;
        iaddr  = has_i ? ia : 32'd0;
        dREN   = has_d && (kind != K_DWO);
        dWEN   = wr;
        daddr  = has_d ? da : 32'd0;
        dstore = wr ? dd : 32'd0;
        if (has_d) begin
            wait_low(1'b1);
            @(negedge CLK);
            dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        end
        if (has_i) begin
            wait_low(1'b0);
            @(negedge CLK);
            iREN = 1'b0; iaddr = '0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_iwait"},    32'(iwait),  32'd1);
        chk({tag, "_dwait"},    32'(dwait),  32'd1);
        chk({tag, "_iload"},    iload,       32'd0);
        chk({tag, "_dload"},    dload,       32'd0);
        chk({tag, "_ramREN"},   32'(ramREN), 32'd0);
        chk({tag, "_ramWEN"},   32'(ramWEN), 32'd0);
        chk({tag, "_ramaddr"},  ramaddr,     32'd0);
        chk({tag, "_ramstore"}, ramstore,    32'd0);
        chk({tag, "_memerr"},   32'(memerr), 32'd0);
    endtask

    initial begin : stimulus
        ref_mem[32'h40] = 32'h8C220004;
        ram_mem[32'h40] = 32'h8C220004;

        // reset hold and release
        repeat (3) @(negedge CLK);
        #3;
        check_idle_outputs("reset");
        RST = 1'b0;
        exp_memerr = 1'b0;
        chk_en = 1'b1;
        repeat (20) @(negedge CLK);

        // directed cases
        txn(K_I,   32'h40,  32'h0,   32'h0,        c_NORM, 2);
        txn(K_BTH, 32'h44,  32'h100, 32'h0,        c_NORM, 1);
        txn(K_DW,  32'h0,   32'h200, 32'hDEADBEEF, c_NORM, 1);
        txn(K_DR,  32'h0,   32'h200, 32'h0,        c_NORM, 0);
        txn(K_DR,  32'h0,   32'h180, 32'h0,        c_BUSY, 0);
        txn(K_I,   32'h80,  32'h0,   32'h0,        c_ERRM, 0);

        // data request dropped in cycle 2 of a slow access: no response
        @(negedge CLK);
        ram_mode = c_NORM; ram_lat = 5;
        rq.push_back('{we: 1'b0, re: 1'b1, addr: 32'h300, store: 32'd0});
        dREN = 1'b1; daddr = 32'h300;
        repeat (2) @(negedge CLK);
        dREN = 1'b0; daddr = '0;
        repeat (6) @(negedge CLK);

        // randomized traffic over a small address pool
        for (int k = 0; k < 40; k++) begin
            int    kind, mode, lat;
            word_t ia, da, dd;
            kind = $urandom_range(0, 4);
            mode = ($urandom_range(0, 9) == 0) ? c_ERRM : c_NORM;
            lat  = $urandom_range(0, 3);
            ia   = word_t'($urandom_range(0, 15)) << 2;
            da   = word_t'($urandom_range(0, 15)) << 2;
            dd   = $urandom;
            txn(kind, ia, da, dd, mode, lat);
        end

        // reset in the middle of a granted access
        @(negedge CLK);
        ram_mode = c_BUSY;
        rq.push_back('{we: 1'b0, re: 1'b1, addr: 32'h44, store: 32'd0});
        iREN = 1'b1; iaddr = 32'h44;
        repeat (3) @(negedge CLK);
        chk_en = 1'b0;
        RST = 1'b1;
        @(negedge CLK); #3;
        check_idle_outputs("midreset");
        RST = 1'b0; iREN = 1'b0; iaddr = '0;
        sb.delete();
        rq.delete();
        exp_memerr = 1'b0;
        @(negedge CLK);
        chk_en = 1'b1;
        txn(K_DR, 32'h0, 32'h200, 32'h0, c_NORM, 1);
        repeat (3) @(negedge CLK);

        chk("resp_queue_drained", sb.size(), 32'd0);
        chk("ram_queue_drained",  rq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
